ps2_host_cmd: RTL

//  Host-to-keyboard command sequencer for the PS/2 port. Takes one command byte (e.g. 0xED set-LEDs,
//  0xFF reset) per handshake, owns the open-drain PS/2 clock/data lines while transmitting, then waits
//  for the keyboard's response byte from the existing PS/2 receive path. Sits beside the key decoder;

---
 rtl/ps2_host_cmd.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ps2_host_cmd.sv
// PS/2 host-to-keyboard command sequencer: inhibit, clock out one byte with odd
// parity, check the device ACK, then wait for the 0xFA/0xFE response with resend.
module ps2_host_cmd #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TX_TIMEOUT     = 1500000,
  parameter int RESP_TIMEOUT   = 2000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_block,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_TX, S_ACK, S_WAIT_RESP, S_DONE, S_FAIL
  } state_t;

  localparam logic [20:0] INH_LAST  = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] TX_LAST   = 21'(TX_TIMEOUT - 1);
  localparam logic [20:0] RESP_LAST = 21'(RESP_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      state, state_nx;
  logic [2:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        fall;
  logic [20:0] tmr;
  logic [3:0]  edge_cnt;
  logic [3:0]  retry;
  logic [7:0]  tx_byte;
  logic        tx_par;
  logic        data_q;
  logic [1:0]  code_q, code_nx;
  logic        tmr_clr;

  assign fall = clk_sync[2] & ~clk_sync[1];

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    case (state)
      S_IDLE:    if (cmd_valid) state_nx = S_INHIBIT;
      S_INHIBIT: if (tmr == INH_LAST) state_nx = S_TX;
      S_TX: begin
        if (tmr == TX_LAST) begin
          state_nx = S_FAIL;
          code_nx  = 2'b01;
        end else if (fall && edge_cnt == 4'd9) begin
          state_nx = S_ACK;
        end
      end
      S_ACK: begin
        if (tmr == TX_LAST || (fall && data_sync[1])) begin
          state_nx = S_FAIL;
          code_nx  = 2'b01;
        end else if (fall) begin
          state_nx = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (rx_valid) begin
          if (rx_byte == 8'hFA) begin
            state_nx = S_DONE;
          end else if (rx_byte == 8'hFE && retry < RETRY_MAX) begin
            state_nx = S_INHIBIT;
          end else begin
            state_nx = S_FAIL;
            code_nx  = 2'b11;
          end
        end else if (tmr == RESP_LAST) begin
          state_nx = S_FAIL;
          code_nx  = 2'b10;
        end
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  // ACK keeps running the TX timer: the limit spans the whole host transmission.
  assign tmr_clr = (state_nx != state) && !(state == S_TX && state_nx == S_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      clk_sync  <= '1;
      data_sync <= '1;
      tmr       <= '0;
      edge_cnt  <= '0;
      retry     <= '0;
      tx_byte   <= '0;
      tx_par    <= 1'b0;
      data_q    <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state     <= state_nx;
      code_q    <= code_nx;
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      if (tmr_clr)              tmr <= '0;
      else if (state != S_IDLE) tmr <= tmr + 21'd1;
      case (state)
        S_IDLE: if (cmd_valid) begin
          tx_byte <= cmd_byte;
          tx_par  <= ~^cmd_byte;
          retry   <= '0;
        end
        S_INHIBIT: begin
          data_q   <= 1'b1;  // start bit, held into TX until the first edge
          edge_cnt <= '0;
        end
        S_TX: if (fall) begin
          edge_cnt <= edge_cnt + 4'd1;
          if (edge_cnt < 4'd8)       data_q <= ~tx_byte[edge_cnt[2:0]];
          else if (edge_cnt == 4'd8) data_q <= ~tx_par;
          else                       data_q <= 1'b0;
        end
        S_WAIT_RESP: if (state_nx == S_INHIBIT) retry <= retry + 4'd1;
        default: ;
      endcase
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rx_block    = (state == S_INHIBIT) || (state == S_TX) || (state == S_ACK);
  assign ps2_clk_oe  = (state == S_INHIBIT);
  assign ps2_data_oe = ((state == S_INHIBIT) && (tmr == INH_LAST)) ||
                       (((state == S_TX) || (state == S_ACK)) && data_q);
  assign done        = (state == S_DONE);
  assign err         = (state == S_FAIL);
  assign err_code    = code_q;

endmodule
